// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes rx, majority-votes three mid-bit samples per bit,
// assembles LSB-first data and reports each frame as a one-cycle valid or framing-error pulse.
module uart_rx_deframer #(
  parameter int DATA_BITS   = 8,
  parameter int DIVISION    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DIVISION);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int M     = DIVISION / 2;

  localparam logic [CNT_W-1:0] T_S0   = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] T_S1   = CNT_W'(M);
  localparam logic [CNT_W-1:0] T_S2   = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(DIVISION - 1);
  localparam logic [BIT_W-1:0] B_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_d;
  logic                   armed_q, armed_d;
  logic                   rx_valid_d, frame_err_d;
  logic                   vote;

  // Input synchronizer: resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // Voting on the updated sample set lets STOP decide on the very tick of its last sample
  assign vote = maj3(smp_d);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (sample_tick && state_q != IDLE) begin
      if (tick_cnt_q == T_S0) smp_d[0] = rx_s;
      if (tick_cnt_q == T_S1) smp_d[1] = rx_s;
      if (tick_cnt_q == T_S2) smp_d[2] = rx_s;
      tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
    end

    if (sample_tick) begin
      unique case (state_q)
        IDLE: begin
          armed_d    = rx_s;
          tick_cnt_d = '0;
          if (armed_q && !rx_s) begin
            // The detecting tick is tick 0, so the next tick processed is tick 1
            state_d    = START;
            tick_cnt_d = CNT_W'(1);
          end
        end
        START: begin
          if (tick_cnt_q == T_LAST) begin
            if (!vote) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d    = IDLE;
              tick_cnt_d = '0;
            end
          end
        end
        DATA: begin
          if (tick_cnt_q == T_LAST) begin
            shift_d              = shift_q >> 1;
            shift_d[DATA_BITS-1] = vote;
            bit_cnt_d            = bit_cnt_q + 1'b1;
            if (bit_cnt_q == B_LAST) state_d = STOP;
          end
        end
        STOP: begin
          if (tick_cnt_q == T_S2) begin
            rx_data_d   = shift_q;
            rx_valid_d  = vote;
            frame_err_d = !vote;
            armed_d     = vote;
            state_d     = IDLE;
            tick_cnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed frames plus random frames, compared against
// a frame-level expectation of pulses and captured bytes.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_err = 0;
  int exp_valid = 0, exp_err = 0;
  logic [7:0] cap_data = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic       prev_pulse = 1'b0;
  int         tdiv = 0;

  uart_rx_deframer #(.DATA_BITS(8), .DIVISION(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One sample tick every 27 clocks
  always @(posedge clk) begin
    if (tdiv == 26) begin
      tdiv        <= 0;
      sample_tick <= 1'b1;
    end else begin
      tdiv        <= tdiv + 1;
      sample_tick <= 1'b0;
    end
  end

  // Record every output pulse; pulses must be single-cycle and mutually exclusive
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      total++;
      assert (!(rx_valid && frame_err) && !prev_pulse) else begin
        bad++;
        $error("FAIL pulse_shape observed valid=%0b err=%0b prev=%0b expected one exclusive 1-clk pulse",
               rx_valid, frame_err, prev_pulse);
      end
      if (rx_valid)  n_valid++;
      if (frame_err) n_err++;
      cap_data = rx_data;
    end
    prev_pulse = rx_valid || frame_err;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge clk); while (!sample_tick);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < 16; t++) begin
        rx = (i == glitch_bit && t == 8) ? ~b[i] : b[i];
        wait_ticks(1);
      end
    end
    rx = stop_bit;
    wait_ticks(16);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_valid_cnt"}, n_valid, exp_valid);
    chk({tag, "_err_cnt"}, n_err, exp_err);
    chk({tag, "_data"}, int'(cap_data), int'(exp_data));
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       st;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", int'(rx_data), 0);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    wait_ticks(32);

    send_frame(8'h55, 1'b1, -1);
    exp_valid++; exp_data = 8'h55;
    check_frame("f55");
    wait_ticks(16);

    send_frame(8'hA3, 1'b1, 2);
    exp_valid++; exp_data = 8'hA3;
    check_frame("fA3_glitch");
    wait_ticks(16);

    rx = 1'b0;
    wait_ticks(4);
    chk("false_start_busy", int'(busy), 1);
    rx = 1'b1;
    wait_ticks(20);
    check_frame("false_start");

    send_frame(8'hC3, 1'b0, -1);
    wait_ticks(40 * 16);
    exp_err++; exp_data = 8'hC3;
    check_frame("fC3_break");
    rx = 1'b1;
    wait_ticks(16);
    send_frame(8'h3C, 1'b1, -1);
    exp_valid++; exp_data = 8'h3C;
    check_frame("f3C_after_break");

    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      wait_ticks(16);
    end
    chk("midframe_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", int'(rx_data), 0);
    chk("midrst_valid", int'(rx_valid), 0);
    chk("midrst_ferr", int'(frame_err), 0);
    chk("midrst_busy", int'(busy), 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(32);
    chk("midrst_no_pulse", n_valid + n_err, exp_valid + exp_err);
    send_frame(8'h0F, 1'b1, -1);
    exp_valid++; exp_data = 8'h0F;
    check_frame("f0F_after_rst");

    send_frame(8'h12, 1'b1, -1);
    chk("b2b_first_data", int'(cap_data), 32'h12);
    send_frame(8'h34, 1'b1, -1);
    exp_valid += 2; exp_data = 8'h34;
    check_frame("b2b");

    for (int k = 0; k < 4; k++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      send_frame(b, st, -1);
      if (st) exp_valid++;
      else    exp_err++;
      exp_data = b;
      rx = 1'b1;
      wait_ticks(1 + $urandom_range(0, 16));
      check_frame("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
